// File: rtl/hlsm_operand_sequencer.sv
// Operand feeder and result collector for the 34-operand HLSM adder.
// Serial words become a stable parallel bus; one Start per job; the result is returned on a valid/ready port.
module hlsm_operand_sequencer #(
  parameter int NUM_OPS     = 34,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255,
  parameter int DRAIN_CYC   = 40
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      in_ready,
  output logic [NUM_OPS*DATA_W-1:0] op_bus,
  output logic                      hlsm_start,
  input  logic                      hlsm_done,
  input  logic [DATA_W-1:0]         hlsm_final,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int IDX_W = $clog2(NUM_OPS);
  localparam int RUN_W = $clog2(TIMEOUT_CYC + 1);
  localparam int DRN_W = $clog2(DRAIN_CYC + 1);

  typedef enum logic [1:0] {LOAD, START, RUN, OUT} state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [RUN_W-1:0]  run_cnt;
  logic [DRN_W-1:0]  drain_cnt;

  // Start fires in the single START cycle where the HLSM is known to be drained.
  assign in_ready   = (state == LOAD);
  assign busy       = (state != LOAD);
  assign hlsm_start = (state == START) && (drain_cnt == '0);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= LOAD;
      op_bus      <= '0;
      idx         <= '0;
      run_cnt     <= '0;
      drain_cnt   <= DRN_W'(DRAIN_CYC);
      out_valid   <= 1'b0;
      out_data    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (drain_cnt != '0)
        drain_cnt <= drain_cnt - 1'b1;

      case (state)
        LOAD: begin
          if (in_valid) begin
            op_bus[int'(idx)*DATA_W +: DATA_W] <= in_data;
            if (idx == IDX_W'(NUM_OPS - 1)) begin
              idx   <= '0;
              state <= START;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end

        START: begin
          if (drain_cnt == '0) begin
            run_cnt <= '0;
            state   <= RUN;
          end
        end

        // op_bus is frozen here; done takes priority over an expiring timeout.
        RUN: begin
          run_cnt <= run_cnt + 1'b1;
          if (hlsm_done) begin
            out_data  <= hlsm_final;
            out_valid <= 1'b1;
            state     <= OUT;
          end else if (run_cnt == RUN_W'(TIMEOUT_CYC - 1)) begin
            timeout_err <= 1'b1;
            drain_cnt   <= DRN_W'(DRAIN_CYC);
            state       <= LOAD;
          end
        end

        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= LOAD;
          end
        end

        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_hlsm_operand_sequencer.sv
// Directed bench for hlsm_operand_sequencer with a stub HLSM that returns the
// modular sum of the 34 operands 36 cycles after Start.
module tb_hlsm_operand_sequencer;

  localparam int NOPS = 34;
  localparam int DW   = 32;

  logic               Clk = 1'b0;
  logic               Rst;
  logic               in_valid;
  logic [DW-1:0]      in_data;
  logic               in_ready;
  logic [NOPS*DW-1:0] op_bus;
  logic               hlsm_start;
  logic               hlsm_done;
  logic [DW-1:0]      hlsm_final;
  logic               out_valid;
  logic [DW-1:0]      out_data;
  logic               out_ready;
  logic               busy;
  logic               timeout_err;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;
  int starts   = 0;
  int ovs      = 0;

  logic [DW-1:0]      words [NOPS];
  logic [NOPS*DW-1:0] exp_bus;
  logic [5:0]         hl_cnt = '0;
  logic               hang;
  logic               force_done;

  hlsm_operand_sequencer #(
    .NUM_OPS(NOPS), .DATA_W(DW), .TIMEOUT_CYC(255), .DRAIN_CYC(40)
  ) dut (
    .Clk(Clk), .Rst(Rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .op_bus(op_bus),
    .hlsm_start(hlsm_start), .hlsm_done(hlsm_done), .hlsm_final(hlsm_final),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (hlsm_start) starts <= starts + 1;
    if (out_valid)  ovs    <= ovs + 1;
  end

  // Stub HLSM: no reset, Done 36 cycles after the Start cycle unless hung.
  always @(posedge Clk) begin
    if (hlsm_start && !hang) hl_cnt <= 6'd36;
    else if (hl_cnt != 6'd0) hl_cnt <= hl_cnt - 6'd1;
  end

  function automatic logic [DW-1:0] stub_sum(input logic [NOPS*DW-1:0] b);
    logic [DW-1:0] s;
    s = '0;
    for (int i = 0; i < NOPS; i++) s = s + b[i*DW +: DW];
    return s;
  endfunction

  assign hlsm_done = (hl_cnt == 6'd1) || force_done;
  always_comb hlsm_final = stub_sum(op_bus);

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load_job(input bit gaps);
    for (int i = 0; i < NOPS; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          in_data  = 32'hDEAD_0000 | i;
          @(negedge Clk);
        end
      end
      in_valid = 1'b1;
      in_data  = words[i];
      @(negedge Clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_start(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (hlsm_start) begin
        ok = 1'b1;
        return;
      end
      @(negedge Clk);
    end
  endtask

  task automatic wait_out(input int limit, output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    while (n < limit) begin
      @(negedge Clk);
      n++;
      if (out_valid) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset;
    Rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    hang = 1'b0; force_done = 1'b0;
    repeat (3) @(negedge Clk);
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (hlsm_start !== 1'b0) $display("FAIL rst_start got %b want 0", hlsm_start); else pass_cnt++;
    chk_cnt++; if (timeout_err !== 1'b0) $display("FAIL rst_timeout got %b want 0", timeout_err); else pass_cnt++;
    chk_cnt++; if (op_bus !== '0) $display("FAIL rst_op_bus got %h want 0", op_bus); else pass_cnt++;
    chk_cnt++; if (out_data !== '0) $display("FAIL rst_out_data got %h want 0", out_data); else pass_cnt++;
    Rst = 1'b0;
    @(negedge Clk);
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b want 1", in_ready); else pass_cnt++;
    repeat (45) @(negedge Clk);
  endtask

  task automatic test_done_in_load;
    force_done = 1'b1;
    @(negedge Clk);
    force_done = 1'b0;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL load_done_busy got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL load_done_in_ready got %b want 1", in_ready); else pass_cnt++;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL load_done_out_valid got %b want 0", out_valid); else pass_cnt++;
    @(negedge Clk);
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL load_done_out_valid2 got %b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_basic_sum;
    bit ok; int n; int s0;
    for (int i = 0; i < NOPS; i++) words[i] = DW'(i + 1);
    s0 = starts;
    out_ready = 1'b1;
    load_job(1'b0);
    wait_start(100, ok);
    chk_cnt++; if (!ok) $display("FAIL basic_start got none want pulse"); else pass_cnt++;
    wait_out(300, n, ok);
    chk_cnt++; if (n !== 37) $display("FAIL basic_latency got %0d want 37", n); else pass_cnt++;
    chk_cnt++; if (out_data !== 32'd595) $display("FAIL basic_out_data got %0d want 595", out_data); else pass_cnt++;
    @(negedge Clk);
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_one_cycle got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL basic_in_ready got %b want 1", in_ready); else pass_cnt++;
    chk_cnt++; if (starts - s0 !== 1) $display("FAIL basic_start_count got %0d want 1", starts - s0); else pass_cnt++;
  endtask

  task automatic test_wrap;
    bit ok; int n;
    for (int i = 0; i < NOPS; i++) words[i] = 32'hFFFF_FFFF;
    load_job(1'b0);
    wait_start(100, ok);
    wait_out(300, n, ok);
    chk_cnt++; if (!ok || out_data !== 32'hFFFF_FFDE) $display("FAIL wrap_out_data got %h want ffffffde", out_data); else pass_cnt++;
    @(negedge Clk);
  endtask

  task automatic test_stall;
    bit ok; int n;
    for (int i = 0; i < NOPS; i++) begin
      words[i] = DW'(256 * (i + 1) + i);
      exp_bus[i*DW +: DW] = words[i];
    end
    out_ready = 1'b0;
    load_job(1'b1);
    chk_cnt++; if (op_bus !== exp_bus) $display("FAIL stall_op_bus got %h want %h", op_bus, exp_bus); else pass_cnt++;
    wait_start(100, ok);
    wait_out(300, n, ok);
    chk_cnt++; if (!ok || out_data !== 32'd152881) $display("FAIL stall_out_data got %0d want 152881", out_data); else pass_cnt++;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_data  = 32'hBAD0_0000 | k;
      @(negedge Clk);
      chk_cnt++; if (out_valid !== 1'b1) $display("FAIL stall_hold_valid cycle %0d got %b want 1", k, out_valid); else pass_cnt++;
      chk_cnt++; if (out_data !== 32'd152881) $display("FAIL stall_hold_data cycle %0d got %0d want 152881", k, out_data); else pass_cnt++;
      chk_cnt++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready cycle %0d got %b want 0", k, in_ready); else pass_cnt++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge Clk);
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL stall_release got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL stall_in_ready_after got %b want 1", in_ready); else pass_cnt++;
    chk_cnt++; if (op_bus !== exp_bus) $display("FAIL stall_op_bus_kept got %h want %h", op_bus, exp_bus); else pass_cnt++;
  endtask

  task automatic test_reset_mid_run;
    bit ok; int n; int rc; int o0;
    for (int i = 0; i < NOPS; i++) words[i] = DW'(i + 1);
    load_job(1'b0);
    wait_start(100, ok);
    repeat (10) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    rc = cyc;
    o0 = ovs;
    for (int i = 0; i < NOPS; i++) words[i] = DW'(2 * (i + 1));
    load_job(1'b0);
    wait_start(100, ok);
    chk_cnt++; if (!ok || cyc - rc !== 40) $display("FAIL rmr_start_delay got %0d want 40", cyc - rc); else pass_cnt++;
    wait_out(300, n, ok);
    chk_cnt++; if (n !== 37) $display("FAIL rmr_latency got %0d want 37", n); else pass_cnt++;
    chk_cnt++; if (out_data !== 32'd1190) $display("FAIL rmr_out_data got %0d want 1190", out_data); else pass_cnt++;
    @(negedge Clk);
    chk_cnt++; if (ovs - o0 !== 1) $display("FAIL rmr_out_count got %0d want 1", ovs - o0); else pass_cnt++;
  endtask

  task automatic test_timeout;
    bit ok; bit saw_ov; int n;
    for (int i = 0; i < NOPS; i++) words[i] = DW'(i + 1);
    hang = 1'b1;
    load_job(1'b0);
    wait_start(100, ok);
    saw_ov = 1'b0;
    n = 0;
    while (n < 400 && timeout_err !== 1'b1) begin
      @(negedge Clk);
      n++;
      if (out_valid) saw_ov = 1'b1;
    end
    chk_cnt++; if (n !== 256) $display("FAIL timeout_cycles got %0d want 256", n); else pass_cnt++;
    chk_cnt++; if (saw_ov !== 1'b0) $display("FAIL timeout_no_out got %b want 0", saw_ov); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL timeout_back_to_load got ready=%b busy=%b want 1/0", in_ready, busy); else pass_cnt++;
    hang = 1'b0;
    load_job(1'b0);
    wait_start(100, ok);
    wait_out(300, n, ok);
    chk_cnt++; if (!ok || out_data !== 32'd595) $display("FAIL timeout_next_job got %0d want 595", out_data); else pass_cnt++;
    chk_cnt++; if (timeout_err !== 1'b1) $display("FAIL timeout_sticky got %b want 1", timeout_err); else pass_cnt++;
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    chk_cnt++; if (timeout_err !== 1'b0) $display("FAIL timeout_clear got %b want 0", timeout_err); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_done_in_load();
    test_basic_sum();
    test_wrap();
    test_stall();
    test_reset_mid_run();
    test_timeout();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
